frame_bram_reader: RTL and testbench

Playback engine for the 8-bit frame buffer BRAM. It reads the stored 640x400 frame (RGB 3-3-2, addresses 0..255999) in raster order. It times each read against hcount/vcount and the window offsets, compensates for BRAM read latency, and expands each byte back to a 24-bit pixel for the video mux. It sits on the read port of the frame BRAM, downstream of the frame capture logic that fills it.

---
 rtl/frame_bram_reader.sv | 124 ++++++++++++
 tb/tb_frame_bram_reader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_bram_reader.sv
// Raster-order playback of the 8-bit RGB332 frame BRAM, timed to the window
// origin, with a BRAM-latency-matched valid line and expansion to 24-bit pixels.
module frame_bram_reader #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 400,
    parameter int FRAME_WORDS  = 256000,
    parameter int BRAM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play,
    input  logic        frame_ready,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [10:0] hoffset,
    input  logic [9:0]  voffset,
    output logic [17:0] bram_addr,
    input  logic [7:0]  bram_dout,
    output logic [23:0] pixel_out,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic [1:0]  reader_state
);

    localparam int LAT = (BRAM_LATENCY < 1) ? 1 : ((BRAM_LATENCY > 4) ? 4 : BRAM_LATENCY);
    localparam logic [11:0] H_SPAN    = 12'(H_ACTIVE);
    localparam logic [10:0] V_SPAN    = 11'(V_ACTIVE);
    localparam logic [17:0] LAST_ADDR = 18'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        PLAYING = 2'b10,
        UNUSED  = 2'b11
    } state_t;

    state_t      state, state_next;
    logic [17:0] read_cnt, cnt_next;
    logic [11:0] h_end;
    logic [10:0] v_end;
    logic        in_window, at_origin, fetch;
    logic [LAT:1] fetch_pipe;
    logic [LAT:0] vld_pipe;
    logic [2:0]  r, g;
    logic [1:0]  b;
    logic [23:0] pixel_expanded;

    // Window ends are widened by one bit so the upper bound never wraps.
    assign h_end     = {1'b0, hoffset} + H_SPAN;
    assign v_end     = {1'b0, voffset} + V_SPAN;
    assign in_window = (hcount >= hoffset) && ({1'b0, hcount} < h_end) &&
                       (vcount >= voffset) && ({1'b0, vcount} < v_end);
    assign at_origin = (hcount == hoffset) && (vcount == voffset);

    // The origin fetch overlaps the ARMED->PLAYING transition cycle.
    assign fetch = in_window &&
                   ((state == PLAYING) ||
                    ((state == ARMED) && at_origin && frame_ready && play));

    assign frame_done   = fetch && (read_cnt == LAST_ADDR);
    assign bram_addr    = read_cnt;
    assign reader_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            read_cnt <= '0;
        end else begin
            state    <= state_next;
            read_cnt <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = read_cnt;
        if (!play) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if ((state == PLAYING) && !frame_ready) begin
            state_next = ARMED;
            cnt_next   = '0;
        end else begin
            if (fetch)
                cnt_next = frame_done ? '0 : read_cnt + 18'd1;
            case (state)
                IDLE: begin
                    state_next = ARMED;
                    cnt_next   = '0;
                end
                ARMED: begin
                    if (at_origin && frame_ready)
                        state_next = PLAYING;
                end
                PLAYING: ;
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Stage 0 is the live fetch; stage LAT lines up with registered BRAM data.
    always_comb vld_pipe = {fetch_pipe, fetch};

    assign r = bram_dout[7:5];
    assign g = bram_dout[4:2];
    assign b = bram_dout[1:0];
    assign pixel_expanded = {r, r, r[2:1], g, g, g[2:1], b, b, b, b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pipe <= '0;
            pixel_out  <= '0;
        end else begin
            fetch_pipe <= vld_pipe[LAT-1:0];
            pixel_out  <= vld_pipe[LAT-1] ? pixel_expanded : 24'h0;
        end
    end

    assign pixel_valid = fetch_pipe[LAT];

endmodule

// File: tb/tb_frame_bram_reader.sv
// Randomized bench for frame_bram_reader on a scaled 16x8 window, checked
// against a cycle-level reference model of the playback rules.
module tb_frame_bram_reader;

    localparam int HA  = 16;
    localparam int VA  = 8;
    localparam int FW  = HA * VA;
    localparam int LAT = 2;
    localparam int HT  = 24;
    localparam int VT  = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        play = 1'b0;
    logic        frame_ready = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic [10:0] hoffset = '0;
    logic [9:0]  voffset = '0;
    logic [17:0] bram_addr;
    logic [7:0]  bram_dout = '0;
    logic [23:0] pixel_out;
    logic        pixel_valid;
    logic        frame_done;
    logic [1:0]  reader_state;

    logic [7:0] mem [FW];

    int n_checks = 0;
    int n_fail   = 0;
    int n_cyc    = 0;

    // Reference model state
    int m_mode;
    int m_cnt;
    bit hv[$];
    int ha[$];

    bit w_rst = 1'b1, w_play = 1'b0, w_fr = 1'b0;
    int w_hoff = 0, w_voff = 0;

    frame_bram_reader #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .FRAME_WORDS(FW), .BRAM_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .play(play), .frame_ready(frame_ready),
        .hcount(hcount), .vcount(vcount), .hoffset(hoffset), .voffset(voffset),
        .bram_addr(bram_addr), .bram_dout(bram_dout), .pixel_out(pixel_out),
        .pixel_valid(pixel_valid), .frame_done(frame_done), .reader_state(reader_state)
    );

    always #5 clk = ~clk;

    // Synchronous-read BRAM: together with the reader's output register this
    // gives two cycles from address to pixel.
    always @(posedge clk) bram_dout <= mem[int'(bram_addr) % FW];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] expand(input logic [7:0] d);
        int rr, gg, bb;
        rr = int'(d[7:5]);
        gg = int'(d[4:2]);
        bb = int'(d[1:0]);
        return {8'((rr * 73) >> 1), 8'((gg * 73) >> 1), 8'(bb * 85)};
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_cnt  = 0;
        hv.delete();
        ha.delete();
        repeat (LAT) begin
            hv.push_back(1'b0);
            ha.push_back(0);
        end
    endtask

    task automatic check_cycle();
        int h, v, ho, vo, ea;
        bit in_win, at_org, fetch, ev;
        h  = int'(hcount);
        v  = int'(vcount);
        ho = int'(hoffset);
        vo = int'(voffset);
        if (rst) begin
            model_reset();
            chk("rst_hold_addr", 32'(bram_addr), 0);
            chk("rst_hold_state", 32'(reader_state), 0);
            chk("rst_hold_valid", 32'(pixel_valid), 0);
            chk("rst_hold_pix", 32'(pixel_out), 0);
            return;
        end
        in_win = (h >= ho) && (h < ho + HA) && (v >= vo) && (v < vo + VA);
        at_org = (h == ho) && (v == vo);
        fetch  = in_win && (m_mode == 2 || (m_mode == 1 && at_org && frame_ready && play));
        ev = hv.pop_front();
        ea = ha.pop_front();
        chk("addr", 32'(bram_addr), m_cnt);
        chk("state", 32'(reader_state), m_mode);
        chk("frame_done", 32'(frame_done), 32'(fetch && m_cnt == FW - 1));
        chk("pixel_valid", 32'(pixel_valid), 32'(ev));
        chk("pixel_out", 32'(pixel_out), ev ? 32'(expand(mem[ea])) : 32'h0);
        hv.push_back(fetch);
        ha.push_back(m_cnt);
        if (!play) begin
            m_mode = 0;
            m_cnt  = 0;
        end else if (m_mode == 2 && !frame_ready) begin
            m_mode = 1;
            m_cnt  = 0;
        end else begin
            if (fetch) m_cnt = (m_cnt + 1) % FW;
            if (m_mode == 0) m_mode = 1;
            else if (m_mode == 1 && at_org && frame_ready) m_mode = 2;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (int'(hcount) == HT - 1) begin
            hcount = '0;
            vcount = (int'(vcount) == VT - 1) ? 10'd0 : vcount + 10'd1;
        end else begin
            hcount = hcount + 11'd1;
        end
        rst         = w_rst;
        play        = w_play;
        frame_ready = w_fr;
        hoffset     = 11'(w_hoff);
        voffset     = 10'(w_voff);
        n_cyc++;
        #3;
        check_cycle();
    endtask

    task automatic wait_state(input int st, input int budget, input string tag);
        int n;
        n = 0;
        while (int'(reader_state) != st && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, 32'(reader_state), st);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst   = 1'b1;
        w_rst = 1'b1;
        #1;
        chk("rst_addr", 32'(bram_addr), 0);
        chk("rst_valid", 32'(pixel_valid), 0);
        chk("rst_state", 32'(reader_state), 0);
        chk("rst_pix", 32'(pixel_out), 0);
        chk("rst_fd", 32'(frame_done), 0);
        model_reset();
        repeat (2) cycle();
        w_rst = 1'b0;
    endtask

    initial begin
        int nv, t_play, t_val, ph, pv, pa, n;
        logic [23:0] p1, p2;

        for (int i = 0; i < FW; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hE3;

        #2;
        chk("init_addr", 32'(bram_addr), 0);
        chk("init_state", 32'(reader_state), 0);
        chk("init_valid", 32'(pixel_valid), 0);
        chk("init_pix", 32'(pixel_out), 0);
        chk("init_fd", 32'(frame_done), 0);
        model_reset();
        repeat (3) cycle();
        w_rst = 1'b0;
        repeat (2) cycle();

        // First pixel and frame wrap, window at (0,0)
        w_hoff = 0; w_voff = 0; w_play = 1'b1; w_fr = 1'b1;
        nv = 0; t_play = -1; t_val = -1; p1 = '0; p2 = '0;
        repeat (4 * HT * VT) begin
            cycle();
            if (reader_state == 2'b10 && t_play < 0) t_play = n_cyc;
            if (frame_done) chk("fd_addr", 32'(bram_addr), FW - 1);
            if (pixel_valid) begin
                nv++;
                if (t_val < 0) t_val = n_cyc;
                if (nv == 1) p1 = pixel_out;
                if (nv == FW + 1) p2 = pixel_out;
            end
        end
        chk("first_pix", 32'(p1), 32'hFF00FF);
        chk("wrap_pix", 32'(p2), 32'hFF00FF);
        chk("first_lat", t_val - (t_play - 1), LAT);

        // Offset window: origin at (5,3), columns 4 and 21 never fetched
        w_play = 1'b0;
        repeat (3) cycle();
        w_hoff = 5; w_voff = 3; w_play = 1'b1;
        n = 0; ph = 0; pv = 0;
        while (reader_state != 2'b10 && n < 2 * HT * VT) begin
            ph = int'(hcount); pv = int'(vcount);
            cycle();
            n++;
        end
        chk("p3_play", 32'(reader_state), 2);
        chk("origin_h", ph, 5);
        chk("origin_v", pv, 3);
        repeat (LAT) cycle();
        nv = 0;
        repeat (HT * VT) begin
            ph = int'(hcount); pv = int'(vcount); pa = int'(bram_addr);
            cycle();
            if (pixel_valid) nv++;
            if (int'(bram_addr) != pa)
                chk("fetch_pos", 32'(ph >= 5 && ph < 21 && pv >= 3 && pv < 11), 1);
        end
        chk("frame_valids", nv, FW);

        // frame_ready drop mid-play, then restart at address 0
        repeat ($urandom_range(30, 90)) cycle();
        w_fr = 1'b0;
        cycle();
        cycle();
        chk("drop_state", 32'(reader_state), 1);
        chk("drop_addr", 32'(bram_addr), 0);
        repeat (20) cycle();
        w_fr = 1'b1;
        wait_state(2, 2 * HT * VT, "restart_play");
        chk("restart_addr", 32'(bram_addr), 1);

        // play and frame_ready dropped together: play wins
        repeat (10) cycle();
        w_play = 1'b0; w_fr = 1'b0;
        cycle();
        cycle();
        chk("both_state", 32'(reader_state), 0);

        // Asynchronous reset mid-play, then re-arm with play held
        w_play = 1'b1; w_fr = 1'b1;
        wait_state(2, 2 * HT * VT, "pre_rst_play");
        repeat (60) cycle();
        async_reset();
        wait_state(2, 2 * HT * VT, "post_rst_play");

        // Random control and window movement
        repeat (6000) begin
            if ($urandom_range(0, 199) == 0) w_play = ~w_play;
            if ($urandom_range(0, 149) == 0) w_fr = ~w_fr;
            if (hcount == 11'd0 && vcount == 10'd0 && $urandom_range(0, 2) == 0) begin
                w_hoff = $urandom_range(0, 10);
                w_voff = $urandom_range(0, 5);
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
